qam_modulator: RTL and testbench
================================

QAM_MODULATOR -- requirements
Module: qam_modulator

Interface
REQ-001 Parameter SAMPLES_PER_SYMBOL, default 10, is the number of step_in pulses per symbol; legal range 2..1024.
REQ-002 clk_in  input  1  system clock; all logic on posedge.
REQ-003 rst_in  input  1  reset, synchronous, active-high.
REQ-004 step_in  input  1  one-cycle sample strobe, the same strobe that drives the carrier generators.
REQ-005 cos_in  input  16  signed in-phase carrier sample.
REQ-006 sin_in  input  16  signed quadrature carrier sample.
REQ-007 symbol_in  input  4  16-QAM symbol; [3:2] selects I, [1:0] selects Q.
REQ-008 symbol_valid_in  input  1  symbol_in valid.
REQ-009 symbol_ready_out  output  1  block can accept a symbol this cycle.
REQ-010 amp_out  output  16  signed modulated sample.
REQ-011 amp_valid_out  output  1  amp_out valid, one-cycle pulse.
REQ-012 underflow_out  output  1  one-cycle pulse: symbol boundary reached with no symbol buffered.

Function
REQ-013 One-entry input buffer; transfer occurs when symbol_valid_in && symbol_ready_out; symbol_ready_out is registered and equals NOT buffer-full.
REQ-014 Sample counter counts 0..SAMPLES_PER_SYMBOL-1; it advances only on step_in and wraps from SAMPLES_PER_SYMBOL-1 to 0.
REQ-015 On step_in with count==0 and the buffer full, the buffered symbol becomes the active symbol and the buffer empties; symbol_ready_out rises the next cycle.
REQ-016 On step_in with count==0 and the buffer empty, the active symbol becomes I=Q=0 and underflow_out pulses one cycle after step_in.
REQ-017 If a transfer and a buffer consume fall in the same cycle, the consume applies first; this cannot occur because ready is low while full.
REQ-018 The sample produced for a count==0 step_in uses the newly loaded active symbol.
REQ-019 Level map with Gray mapping disabled (per 2-bit field): 00->-3, 01->-1, 10->+1, 11->+3.
REQ-020 Stage 1, registered on step_in: pI = I*cos_in and pQ = Q*sin_in, each 19-bit signed, with cos_in and sin_in sampled in the step_in cycle.
REQ-021 Stage 2: s = pI - pQ as 20-bit signed; amp_out = s >>> 3 (arithmetic, floor), always within 16-bit range, no saturation.
REQ-022 amp_valid_out pulses exactly 2 cycles after each step_in; amp_out holds its value between pulses.
REQ-023 Back-to-back step_in on consecutive cycles are fully pipelined, one output per step_in.

Reset
REQ-024 While rst_in is high: amp_out=0, amp_valid_out=0, underflow_out=0, symbol_ready_out=0, count=0, buffer empty, active symbol I=Q=0, pipeline valids cleared.
REQ-025 symbol_ready_out=1 on the first cycle after rst_in deasserts.
REQ-026 Reset mid-symbol or mid-pipeline discards the buffered symbol and any in-flight samples; no amp_valid_out pulse for them.

Configuration
REQ-027 Macro QAM_GRAY_MAP_EN defined: Gray level map per field 00->-3, 01->-1, 11->+1, 10->+3.
REQ-028 QAM_GRAY_MAP_EN undefined: natural map of REQ-019; no other behaviour differs.

Verification
REQ-029 SPS=4, natural map; symbol 4'b1111 accepted; cos_in=16384, sin_in=0 -> amp_out=6144 with amp_valid_out 2 cycles after each of 4 step_in pulses.
REQ-030 Extreme value: I=+3, Q=+3, cos_in=32767, sin_in=-32768 -> amp_out=24575; I=-3, Q=+3, cos_in=32767, sin_in=32767 -> amp_out=-24576.
REQ-031 QAM_GRAY_MAP_EN defined, symbol 4'b1010, cos_in=8192, sin_in=8192 -> amp_out=0; symbol 4'b1000 (I=+3, Q=-3) -> amp_out=6144.
REQ-032 No symbol offered, step_in at count 0 -> underflow_out pulse 1 cycle later; amp_out=0 for all SPS samples.
REQ-033 Backpressure: symbol_valid_in held high with two symbols -> first accepted, ready low until the next count-0 step_in, second accepted the cycle after ready rises; symbols emitted in order, none dropped.
REQ-034 rst_in asserted at count=2 with the buffer full -> all outputs 0 next cycle, no stale amp_valid_out, ready=1 after release, and the next count-0 step underflows.

Source files
------------

// File: rtl/qam_modulator.sv
// qam_modulator: 16-QAM symbol buffer, level mapper and I/Q carrier mixer.
// Define QAM_GRAY_MAP_EN to select the Gray level map instead of the natural map.
module qam_modulator #(
    parameter int SAMPLES_PER_SYMBOL = 10
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               step_in,
    input  logic signed [15:0] cos_in,
    input  logic signed [15:0] sin_in,
    input  logic [3:0]         symbol_in,
    input  logic               symbol_valid_in,
    output logic               symbol_ready_out,
    output logic signed [15:0] amp_out,
    output logic               amp_valid_out,
    output logic               underflow_out
);
    localparam int CW = $clog2(SAMPLES_PER_SYMBOL);
    localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_SYMBOL - 1);

    logic [CW-1:0]      count;
    logic               buf_full, buf_full_next, load, accept, p_valid;
    logic [3:0]         buf_sym;
    logic signed [2:0]  act_i, act_q, lvl_i, lvl_q;
    logic signed [18:0] p_i, p_q;

    function automatic logic signed [2:0] level(input logic [1:0] f);
        logic [1:0]        b;
        logic signed [3:0] v;
`ifdef QAM_GRAY_MAP_EN
        b = {f[1], f[1] ^ f[0]};
`else
        b = f;
`endif
        v = $signed({1'b0, b, 1'b0}) - 4'sd3;
        return v[2:0];
    endfunction

    assign accept        = symbol_valid_in && symbol_ready_out;
    assign load          = step_in && count == '0;
    assign buf_full_next = accept || (buf_full && !load);
    // The count-0 sample already uses the symbol being loaded (or zero on underflow).
    assign lvl_i = load ? (buf_full ? level(buf_sym[3:2]) : 3'sd0) : act_i;
    assign lvl_q = load ? (buf_full ? level(buf_sym[1:0]) : 3'sd0) : act_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count            <= '0;
            buf_full         <= 1'b0;
            buf_sym          <= '0;
            symbol_ready_out <= 1'b0;
            act_i            <= '0;
            act_q            <= '0;
            p_i              <= '0;
            p_q              <= '0;
            p_valid          <= 1'b0;
            amp_out          <= '0;
            amp_valid_out    <= 1'b0;
            underflow_out    <= 1'b0;
        end else begin
            if (step_in)
                count <= count == LAST ? '0 : count + CW'(1);
            if (accept)
                buf_sym <= symbol_in;
            buf_full         <= buf_full_next;
            symbol_ready_out <= !buf_full_next;
            if (load) begin
                act_i <= lvl_i;
                act_q <= lvl_q;
            end
            if (step_in) begin
                p_i <= 19'(lvl_i) * 19'(cos_in);
                p_q <= 19'(lvl_q) * 19'(sin_in);
            end
            p_valid       <= step_in;
            underflow_out <= load && !buf_full;
            // The difference always fits 16 bits after the floor shift, so truncation is exact.
            if (p_valid)
                amp_out <= 16'((20'(p_i) - 20'(p_q)) >>> 3);
            amp_valid_out <= p_valid;
        end
    end
endmodule

// File: tb/tb_qam_modulator.sv
// tb_qam_modulator: directed and randomized checks of qam_modulator against a
// queue-based symbol/sample model evaluated with plain integer arithmetic.
module tb_qam_modulator;
    localparam int SPS = 4;

    logic               clk_in = 1'b0, rst_in = 1'b1, step_in = 1'b0, symbol_valid_in = 1'b0;
    logic signed [15:0] cos_in = '0, sin_in = '0;
    logic [3:0]         symbol_in = '0;
    logic               symbol_ready_out, amp_valid_out, underflow_out;
    logic signed [15:0] amp_out;

    typedef struct {int due; int amp;} ent_t;
    ent_t       exp_q[$];
    logic [3:0] buf_q[$];
    int         now = 0, m_cnt = 0, m_i = 0, m_q = 0, checks = 0, passed = 0;
    logic       e_ready = 1'b0, e_uf = 1'b0, e_av = 1'b0;
    logic signed [15:0] e_amp = '0;

    qam_modulator #(.SAMPLES_PER_SYMBOL(SPS)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .step_in(step_in),
        .cos_in(cos_in), .sin_in(sin_in),
        .symbol_in(symbol_in), .symbol_valid_in(symbol_valid_in),
        .symbol_ready_out(symbol_ready_out), .amp_out(amp_out),
        .amp_valid_out(amp_valid_out), .underflow_out(underflow_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic int lv(input logic [1:0] f);
`ifdef QAM_GRAY_MAP_EN
        case (f)
            2'b00: return -3;
            2'b01: return -1;
            2'b11: return 1;
            default: return 3;
        endcase
`else
        case (f)
            2'b00: return -3;
            2'b01: return -1;
            2'b10: return 1;
            default: return 3;
        endcase
`endif
    endfunction

    function automatic logic [1:0] enc(input int l);
        for (int f = 0; f < 4; f++)
            if (lv(2'(f)) == l) return 2'(f);
        return 2'b00;
    endfunction

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Drives one clock of stimulus, advances the model, and returns at the next negedge.
    task automatic cyc(input bit r, input bit st, input bit v, input logic [3:0] sym, input int c, input int s);
        ent_t       e;
        logic [3:0] y;
        rst_in = r; step_in = st; symbol_valid_in = v; symbol_in = sym;
        cos_in = 16'(c); sin_in = 16'(s);
        now++;
        if (r) begin
            buf_q.delete(); exp_q.delete();
            m_cnt = 0; m_i = 0; m_q = 0;
            e_ready = 1'b0; e_uf = 1'b0; e_av = 1'b0; e_amp = '0;
        end else begin
            e_uf = 1'b0;
            if (st) begin
                if (m_cnt == 0) begin
                    if (buf_q.size() > 0) begin
                        y = buf_q.pop_front();
                        m_i = lv(y[3:2]); m_q = lv(y[1:0]);
                    end else begin
                        m_i = 0; m_q = 0; e_uf = 1'b1;
                    end
                end
                e.due = now + 1;
                e.amp = (m_i * c - m_q * s) >>> 3;
                exp_q.push_back(e);
                m_cnt = (m_cnt + 1) % SPS;
            end
            if (v && e_ready) buf_q.push_back(sym);
            e_ready = buf_q.size() == 0;
            e_av = exp_q.size() > 0 && exp_q[0].due == now;
            if (e_av) begin
                e = exp_q.pop_front();
                e_amp = 16'(e.amp);
            end
        end
        @(negedge clk_in);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(k < 2, 1'b1, 1'b1, 4'hF, 1000, 1000);
            checks++;
            if ({symbol_ready_out, underflow_out, amp_valid_out, amp_out} !== {e_ready, e_uf, e_av, e_amp})
                $display("FAIL reset cyc %0d: got rdy/uf/av/amp %b/%b/%b/%0d want %b/%b/%b/%0d", now,
                         symbol_ready_out, underflow_out, amp_valid_out, amp_out, e_ready, e_uf, e_av, e_amp);
            else passed++;
        end
    endtask

    task automatic test_carrier();
        logic [3:0] sym;
        sym = {enc(3), enc(3)};
        for (int k = 0; k < 15; k++) begin
            cyc(k == 0, k >= 3 && k <= 12 && (k - 3) % 3 == 0, k == 2, sym, 16384, 0);
            checks++;
            if ({symbol_ready_out, underflow_out, amp_valid_out, amp_out} !== {e_ready, e_uf, e_av, e_amp})
                $display("FAIL carrier cyc %0d: got rdy/uf/av/amp %b/%b/%b/%0d want %b/%b/%b/%0d", now,
                         symbol_ready_out, underflow_out, amp_valid_out, amp_out, e_ready, e_uf, e_av, e_amp);
            else passed++;
            if (k == 4 || k == 7 || k == 10 || k == 13) begin
                checks++;
                if (amp_valid_out !== 1'b1 || amp_out !== 16'sd6144)
                    $display("FAIL carrier amp k=%0d: got v=%b amp=%0d want v=1 amp=6144", k, amp_valid_out, amp_out);
                else passed++;
            end
        end
    endtask

    task automatic test_pair(input string name, input logic [3:0] a, input logic [3:0] b,
                             input int c0, input int s0, input int c1, input int s1, input int xa, input int xb);
        int c, s;
        for (int k = 0; k < 10; k++) begin
            c = k == 3 ? c0 : k == 7 ? c1 : rnd16();
            s = k == 3 ? s0 : k == 7 ? s1 : rnd16();
            cyc(k == 0, k >= 3 && k <= 7, k == 2 || k == 4, k == 2 ? a : b, c, s);
            checks++;
            if ({symbol_ready_out, underflow_out, amp_valid_out, amp_out} !== {e_ready, e_uf, e_av, e_amp})
                $display("FAIL %s cyc %0d: got rdy/uf/av/amp %b/%b/%b/%0d want %b/%b/%b/%0d", name, now,
                         symbol_ready_out, underflow_out, amp_valid_out, amp_out, e_ready, e_uf, e_av, e_amp);
            else passed++;
            if (k == 4 || k == 8) begin
                checks++;
                if (amp_valid_out !== 1'b1 || amp_out !== 16'(k == 4 ? xa : xb))
                    $display("FAIL %s amp k=%0d: got v=%b amp=%0d want v=1 amp=%0d", name, k,
                             amp_valid_out, amp_out, k == 4 ? xa : xb);
                else passed++;
            end
        end
    endtask

    task automatic test_underflow();
        for (int k = 0; k < 8; k++) begin
            cyc(k == 0, k >= 2 && k <= 5, 1'b0, 4'h0, rnd16(), rnd16());
            checks++;
            if ({symbol_ready_out, underflow_out, amp_valid_out, amp_out} !== {e_ready, e_uf, e_av, e_amp})
                $display("FAIL underflow cyc %0d: got rdy/uf/av/amp %b/%b/%b/%0d want %b/%b/%b/%0d", now,
                         symbol_ready_out, underflow_out, amp_valid_out, amp_out, e_ready, e_uf, e_av, e_amp);
            else passed++;
            if (k == 2) begin
                checks++;
                if (underflow_out !== 1'b1)
                    $display("FAIL underflow pulse: got %b want 1", underflow_out);
                else passed++;
            end
            if (k >= 3 && k <= 6) begin
                checks++;
                if (amp_valid_out !== 1'b1 || amp_out !== 16'sd0)
                    $display("FAIL underflow zero k=%0d: got v=%b amp=%0d want v=1 amp=0", k, amp_valid_out, amp_out);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a, b;
        bit         b_done, v, tk;
        a = 4'($urandom); b = 4'($urandom); b_done = 1'b0;
        for (int k = 0; k < 16; k++) begin
            v = k >= 2 && !b_done;
            tk = v && e_ready && k >= 3;
            cyc(k == 0, k >= 5 && k <= 12, v, k == 2 ? a : b, rnd16(), rnd16());
            if (tk) b_done = 1'b1;
            checks++;
            if ({symbol_ready_out, underflow_out, amp_valid_out, amp_out} !== {e_ready, e_uf, e_av, e_amp})
                $display("FAIL backpressure cyc %0d: got rdy/uf/av/amp %b/%b/%b/%0d want %b/%b/%b/%0d", now,
                         symbol_ready_out, underflow_out, amp_valid_out, amp_out, e_ready, e_uf, e_av, e_amp);
            else passed++;
            if (k == 3 || k == 5 || k == 6) begin
                checks++;
                if (symbol_ready_out !== (k == 5))
                    $display("FAIL backpressure ready k=%0d: got %b want %b", k, symbol_ready_out, k == 5);
                else passed++;
            end
        end
    endtask

    task automatic test_midreset();
        for (int k = 0; k < 10; k++) begin
            cyc(k == 0 || k == 5, k == 3 || k == 4 || k == 5 || k == 7, k == 2 || k == 4, 4'($urandom), rnd16(), rnd16());
            checks++;
            if ({symbol_ready_out, underflow_out, amp_valid_out, amp_out} !== {e_ready, e_uf, e_av, e_amp})
                $display("FAIL midreset cyc %0d: got rdy/uf/av/amp %b/%b/%b/%0d want %b/%b/%b/%0d", now,
                         symbol_ready_out, underflow_out, amp_valid_out, amp_out, e_ready, e_uf, e_av, e_amp);
            else passed++;
            if (k == 5 || k == 6) begin
                checks++;
                if ({underflow_out, amp_valid_out, amp_out} !== 18'd0 || symbol_ready_out !== (k == 6))
                    $display("FAIL midreset clear k=%0d: got rdy/uf/av/amp %b/%b/%b/%0d want %b/0/0/0", k,
                             symbol_ready_out, underflow_out, amp_valid_out, amp_out, k == 6);
                else passed++;
            end
            if (k == 7) begin
                checks++;
                if (underflow_out !== 1'b1)
                    $display("FAIL midreset underflow: got %b want 1", underflow_out);
                else passed++;
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            cyc(k == 0 || $urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom), 4'($urandom), rnd16(), rnd16());
            checks++;
            if ({symbol_ready_out, underflow_out, amp_valid_out, amp_out} !== {e_ready, e_uf, e_av, e_amp})
                $display("FAIL random cyc %0d: got rdy/uf/av/amp %b/%b/%b/%0d want %b/%b/%b/%0d", now,
                         symbol_ready_out, underflow_out, amp_valid_out, amp_out, e_ready, e_uf, e_av, e_amp);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_carrier();
        test_pair("extreme", {enc(3), enc(3)}, {enc(-3), enc(3)}, 32767, -32768, 32767, 32767, 24575, -24576);
`ifdef QAM_GRAY_MAP_EN
        test_pair("map", 4'b1010, 4'b1000, 8192, 8192, 8192, 8192, 0, 6144);
`else
        test_pair("map", 4'b1010, 4'b1000, 8192, 8192, 8192, 8192, 0, 4096);
`endif
        test_underflow();
        test_back_to_back();
        test_midreset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
